// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, 2-FF row sync, press/release debounce, nibble shift register.
// Optional macro KEYPAD_AUTOREPEAT_EN re-issues the held key every REPEAT_TICKS scan ticks.
`timescale 1ns/1ps
module hex_keypad_scanner #(
    parameter int SCAN_DIV_W   = 15,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_TICKS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    input  logic        key_ack,
    input  logic        key_clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_pending,
    output logic        overrun,
    output logic [15:0] value
);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t                state_reg, state_next;
    logic [SCAN_DIV_W-1:0] div_reg;
    logic [3:0]            rows_meta_reg, rows_sync_reg;
    logic [3:0]            cols_reg, cols_next;
    logic [1:0]            col_idx_reg, col_idx_next;
    logic [3:0]            pattern_reg, pattern_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  key_valid_reg;
    logic [3:0]            key_code_reg;
    logic                  pending_reg, overrun_reg;
    logic [15:0]           value_reg;
    logic                  tick, rows_idle, accept;
    logic [3:0]            cols_rot, accept_code;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    logic [REP_W-1:0]      rep_reg, rep_next;
`endif

    // Index of the lowest low bit; serves both the active-low column drive and the row pattern.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        low_index = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) low_index = 2'(i);
        end
    endfunction

    assign tick        = &div_reg;
    assign rows_idle   = &rows_sync_reg;
    assign cols_rot    = {cols_reg[2:0], cols_reg[3]};
    assign accept_code = {low_index(pattern_reg), col_idx_reg};

    always_comb begin
        state_next   = state_reg;
        cols_next    = cols_reg;
        col_idx_next = col_idx_reg;
        pattern_next = pattern_reg;
        cnt_next     = cnt_reg;
        accept       = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_next     = rep_reg;
`endif
        if (tick) begin
            case (state_reg)
                SCAN: begin
                    if (rows_idle) begin
                        cols_next = cols_rot;
                    end else begin
                        col_idx_next = low_index(cols_reg);
                        pattern_next = rows_sync_reg;
                        cnt_next     = CNT_W'(1);
                        state_next   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (rows_sync_reg == pattern_reg) begin
                        if (cnt_reg == CNT_W'(DEBOUNCE_CNT - 1)) begin
                            accept     = 1'b1;
                            cnt_next   = '0;
                            state_next = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_next   = '0;
`endif
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        cnt_next   = '0;
                        cols_next  = cols_rot;
                        state_next = SCAN;
                    end
                end
                HELD: begin
                    if (rows_idle) begin
                        cnt_next   = CNT_W'(1);
                        state_next = RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_next   = '0;
                    end else if (rep_reg == REP_W'(REPEAT_TICKS - 1)) begin
                        accept   = 1'b1;
                        rep_next = '0;
                    end else begin
                        rep_next = rep_reg + REP_W'(1);
`endif
                    end
                end
                RELEASE: begin
                    if (!rows_idle) begin
                        cnt_next   = '0;
                        state_next = HELD;
                    end else if (cnt_reg == CNT_W'(DEBOUNCE_CNT - 1)) begin
                        cnt_next   = '0;
                        cols_next  = cols_rot;
                        state_next = SCAN;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SCAN;
            div_reg       <= '0;
            rows_meta_reg <= 4'hF;
            rows_sync_reg <= 4'hF;
            cols_reg      <= 4'b1110;
            col_idx_reg   <= 2'd0;
            pattern_reg   <= 4'hF;
            cnt_reg       <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_reg + SCAN_DIV_W'(1);
            rows_meta_reg <= rows;
            rows_sync_reg <= rows_meta_reg;
            cols_reg      <= cols_next;
            col_idx_reg   <= col_idx_next;
            pattern_reg   <= pattern_next;
            cnt_reg       <= cnt_next;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_reg       <= rep_next;
`endif
        end
    end

    // An ack coinciding with an accept leaves the new key pending but wipes any old overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'd0;
            pending_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
            value_reg     <= 16'd0;
        end else begin
            key_valid_reg <= accept;
            if (accept) key_code_reg <= accept_code;
            if (key_clr)     value_reg <= 16'd0;
            else if (accept) value_reg <= {value_reg[11:0], accept_code};
            if (accept)       pending_reg <= 1'b1;
            else if (key_ack) pending_reg <= 1'b0;
            if (key_ack)                    overrun_reg <= 1'b0;
            else if (accept && pending_reg) overrun_reg <= 1'b1;
        end
    end

    assign cols        = cols_reg;
    assign key_valid   = key_valid_reg;
    assign key_code    = key_code_reg;
    assign key_pending = pending_reg;
    assign overrun     = overrun_reg;
    assign value       = value_reg;
endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: physical keypad model, predicted accepts queued, monitor compares on key_valid.
`timescale 1ns/1ps
module tb_hex_keypad_scanner;
    localparam int D = 3;
    localparam int R = 4;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, key_ack = 1'b0, key_clr = 1'b0;
    logic [3:0]  rows, cols, key_code;
    logic        key_valid, key_pending, overrun;
    logic [15:0] value;
    logic [15:0] pressed = 16'h0000;   // bit {row,col} set = that key is held down

    hex_keypad_scanner #(.SCAN_DIV_W(2), .DEBOUNCE_CNT(D), .REPEAT_TICKS(R)) dut (
        .clk(clk), .rst(rst), .rows(rows), .cols(cols), .key_ack(key_ack), .key_clr(key_clr),
        .key_valid(key_valid), .key_code(key_code), .key_pending(key_pending),
        .overrun(overrun), .value(value)
    );

    always #5 clk = ~clk;

    // A row reads low when any held key on it sits in a column currently driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) rows[r] = ~|(pressed[r*4 +: 4] & ~cols);
    end

    typedef struct {
        logic [3:0]  code;
        logic [15:0] value;
        logic        pending;
        logic        overrun;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0, fails = 0;
    logic [15:0] m_value = 16'h0000;
    logic        m_pending = 1'b0, m_overrun = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_key_valid: got code %0h value %0h, required no pulse", key_code, value);
            end else begin
                mon_e = exp_q.pop_front();
                $display("[TB] accept code=%0h value=%04h pending=%0b overrun=%0b", key_code, value, key_pending, overrun);
                check("key_code", key_code, mon_e.code);
                check("value", value, mon_e.value);
                check("key_pending", key_pending, mon_e.pending);
                check("overrun", overrun, mon_e.overrun);
            end
        end
    end

    // A key seen for n scan ticks yields one accept once n reaches D, plus one per R further ticks with auto-repeat.
    task automatic predict(input logic [15:0] keys, input int col, input int n, input bit clr_first, input bit ack_first);
        logic [3:0] code;
        bit         hit;
        int         cnt;
        exp_t       e;
        hit  = 1'b0;
        code = 4'h0;
        for (int r = 3; r >= 0; r--) begin
            if (keys[r*4 + col]) begin
                hit  = 1'b1;
                code = 4'(r * 4 + col);
            end
        end
        cnt = (!hit || n < D) ? 0 : 1 + (AR ? (n - D) / R : 0);
        for (int k = 0; k < cnt; k++) begin
            m_value   = (k == 0 && clr_first) ? 16'h0000 : {m_value[11:0], code};
            m_overrun = (k == 0 && ack_first) ? 1'b0 : (m_overrun | m_pending);
            m_pending = 1'b1;
            e.code = code; e.value = m_value; e.pending = m_pending; e.overrun = m_overrun;
            exp_q.push_back(e);
        end
    endtask

    // Wait for the scan to move onto the given column so the press is seen from the next tick.
    task automatic align(input int col, output bit ok);
        logic [3:0] target, prev;
        target = ~(4'b0001 << col);
        prev   = cols;
        ok     = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cols == target && prev != target) ok = 1'b1;
            prev = cols;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL scan_align: got cols %0h, required %0h within 200 clk", cols, target);
        end
    endtask

    task automatic press(input logic [15:0] keys, input int col, input int n, input bit clr_first, input bit ack_first);
        bit ok;
        align(col, ok);
        if (ok) begin
            predict(keys, col, n, clr_first, ack_first);
            pressed = keys;
            for (int t = 1; t <= n * 4; t++) begin
                @(negedge clk);
                if (t == 4 * D - 1) begin
                    key_clr = clr_first;
                    key_ack = ack_first;
                end
                if (t == 4 * D) begin
                    key_clr = 1'b0;
                    key_ack = 1'b0;
                end
            end
            pressed = 16'h0000;
            repeat ((D + 3) * 4) @(negedge clk);
            check("pulses_outstanding", exp_q.size(), 0);
        end
    endtask

    task automatic do_ack();
        @(negedge clk) key_ack = 1'b1;
        @(negedge clk) key_ack = 1'b0;
        m_pending = 1'b0;
        m_overrun = 1'b0;
        check("ack_pending", key_pending, m_pending);
        check("ack_overrun", overrun, m_overrun);
    endtask

    task automatic check_reset_outputs();
        check("rst_cols", cols, 4'b1110);
        check("rst_value", value, 16'h0000);
        check("rst_pending", key_pending, 1'b0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_code", key_code, 4'h0);
        check("rst_overrun", overrun, 1'b0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_cols;
        bit         ok;
        int         key, n;
        bit         clr, ack;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        exp_cols = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            repeat (4) @(negedge clk);
            exp_cols = {exp_cols[2:0], exp_cols[3]};
            check("idle_cols_rotate", cols, exp_cols);
        end

        press(16'h0400, 2, 5, 1'b0, 1'b0);
        check("single_pending", key_pending, 1'b1);
        do_ack();

        press(16'h0002, 1, 4, 1'b0, 1'b0);
        press(16'h0004, 2, 4, 1'b0, 1'b0);
        press(16'h0008, 3, 4, 1'b0, 1'b0);
        press(16'h0010, 0, 4, 1'b0, 1'b0);
        check("seq_value", value, 16'h1234);
        do_ack();

        align(0, ok);
        if (ok) begin
            for (int b = 0; b < 4; b++) begin
                pressed = 16'h0001;
                repeat (8) @(negedge clk);
                pressed = 16'h0000;
                repeat (4) @(negedge clk);
            end
            repeat (24) @(negedge clk);
        end

        press(16'h1010, 0, 4, 1'b1, 1'b0);
        do_ack();

        press(16'h0020, 1, 20, 1'b0, 1'b0);
        do_ack();

        align(1, ok);
        if (ok) begin
            pressed = 16'h0020;
            predict(pressed, 1, D, 1'b0, 1'b0);
            repeat (4 * D + 4) @(negedge clk);
            rst = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check_reset_outputs();
            check("rst_pulses_outstanding", exp_q.size(), 0);
            m_value = 16'h0000; m_pending = 1'b0; m_overrun = 1'b0;
            predict(pressed, 1, D, 1'b0, 1'b0);
            rst = 1'b0;
            repeat (24) @(negedge clk);
            pressed = 16'h0000;
            repeat (24) @(negedge clk);
            check("redetect_pulses_outstanding", exp_q.size(), 0);
            check("redetect_value", value, 16'h0005);
            do_ack();
        end

        for (int i = 0; i < 12; i++) begin
            key = $urandom_range(0, 15);
            n   = $urandom_range(1, 10);
            clr = (n >= D) && ($urandom_range(0, 3) == 0);
            ack = (n >= D) && !clr && ($urandom_range(0, 3) == 0);
            press(16'(1) << key, key % 4, n, clr, ack);
            if ($urandom_range(0, 1) == 1) do_ack();
        end

        check("final_pulses_outstanding", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
